// File: rtl/axi_slave_bridge.sv
// AXI4 slave to simple single-outstanding memory request/response bridge.
// Bursts are split into one memory transaction per beat by a single FSM.
module axi_slave_bridge #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 128,
  parameter int ID_W   = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [ID_W-1:0]     s_axi_awid,
  input  logic [ADDR_W-1:0]   s_axi_awaddr,
  input  logic [7:0]          s_axi_awlen,
  input  logic [2:0]          s_axi_awsize,
  input  logic [1:0]          s_axi_awburst,
  input  logic                s_axi_awvalid,
  output logic                s_axi_awready,
  input  logic [DATA_W-1:0]   s_axi_wdata,
  input  logic [DATA_W/8-1:0] s_axi_wstrb,
  input  logic                s_axi_wlast,
  input  logic                s_axi_wvalid,
  output logic                s_axi_wready,
  output logic [ID_W-1:0]     s_axi_bid,
  output logic [1:0]          s_axi_bresp,
  output logic                s_axi_bvalid,
  input  logic                s_axi_bready,
  input  logic [ID_W-1:0]     s_axi_arid,
  input  logic [ADDR_W-1:0]   s_axi_araddr,
  input  logic [7:0]          s_axi_arlen,
  input  logic [2:0]          s_axi_arsize,
  input  logic [1:0]          s_axi_arburst,
  input  logic                s_axi_arvalid,
  output logic                s_axi_arready,
  output logic [ID_W-1:0]     s_axi_rid,
  output logic [DATA_W-1:0]   s_axi_rdata,
  output logic [1:0]          s_axi_rresp,
  output logic                s_axi_rlast,
  output logic                s_axi_rvalid,
  input  logic                s_axi_rready,
  output logic                mem_req_valid,
  output logic                mem_req_write,
  output logic [ADDR_W-1:0]   mem_req_addr,
  output logic [DATA_W-1:0]   mem_req_wdata,
  output logic [DATA_W/8-1:0] mem_req_wstrb,
  input  logic                mem_req_ready,
  input  logic                mem_rsp_valid,
  input  logic [DATA_W-1:0]   mem_rsp_rdata,
  input  logic                mem_rsp_err
);

  localparam int MAX_SIZE = $clog2(DATA_W / 8);

  typedef enum logic [2:0] {IDLE, WR_REQ, WR_ACK, WR_RESP, RD_REQ, RD_ACK, RD_DATA} state_t;

  state_t              state;
  logic [ID_W-1:0]     id_q;
  logic [ADDR_W-1:0]   addr_q;
  logic [7:0]          len_q;
  logic [2:0]          size_q;
  logic [1:0]          burst_q;
  logic [7:0]          beat_q;
  logic                illegal_q;
  logic                err_q;
  logic                prio_rd;
  logic [DATA_W-1:0]   rdata_q;
  logic                rresp_err_q;

  logic                grant_wr;
  logic                grant_rd;
  logic                final_beat;
  logic                wr_mem;
  logic                rd_mem;
  logic                w_accept;
  logic [ADDR_W-1:0]   addr_aligned;
  logic [ADDR_W-1:0]   addr_incr;
  logic [ADDR_W-1:0]   wrap_mask;
  logic [ADDR_W-1:0]   addr_nxt;

  function automatic logic is_illegal(input logic [7:0] len, input logic [2:0] size,
                                      input logic [1:0] burst);
    logic bad_wrap;
    bad_wrap = (burst == 2'b10) &&
               !(len == 8'd1 || len == 8'd3 || len == 8'd7 || len == 8'd15);
    return (burst == 2'b11) || (32'(size) > MAX_SIZE) || bad_wrap;
  endfunction

  // Round-robin: the channel not served last wins a simultaneous request.
  assign grant_wr = s_axi_awvalid && (!s_axi_arvalid || !prio_rd);
  assign grant_rd = s_axi_arvalid && !grant_wr;
  assign s_axi_awready = !rst && (state == IDLE) && grant_wr;
  assign s_axi_arready = !rst && (state == IDLE) && grant_rd;

  assign final_beat = (beat_q == len_q);
  assign wr_mem     = (state == WR_REQ) && !illegal_q;
  assign rd_mem     = (state == RD_REQ) && !illegal_q;
  assign w_accept   = (state == WR_REQ) && s_axi_wvalid && (illegal_q || mem_req_ready);

  // Memory is word addressed, so every beat is presented size-aligned.
  assign addr_aligned = addr_q & ~((ADDR_W'(1) << size_q) - ADDR_W'(1));

  always_comb begin
    addr_incr = addr_aligned + (ADDR_W'(1) << size_q);
    wrap_mask = ((ADDR_W'(len_q) + ADDR_W'(1)) << size_q) - ADDR_W'(1);
    case (burst_q)
      2'b00:   addr_nxt = addr_q;
      2'b10:   addr_nxt = (addr_aligned & ~wrap_mask) | (addr_incr & wrap_mask);
      default: addr_nxt = addr_incr;
    endcase
  end

  assign s_axi_wready  = (state == WR_REQ) && (illegal_q || mem_req_ready);
  assign mem_req_valid = (wr_mem && s_axi_wvalid) || rd_mem;
  assign mem_req_write = wr_mem;
  assign mem_req_addr  = (wr_mem || rd_mem) ? addr_aligned : '0;
  assign mem_req_wdata = wr_mem ? s_axi_wdata : '0;
  assign mem_req_wstrb = wr_mem ? s_axi_wstrb : '0;

  assign s_axi_bvalid = (state == WR_RESP);
  assign s_axi_bid    = s_axi_bvalid ? id_q : '0;
  assign s_axi_bresp  = (s_axi_bvalid && err_q) ? 2'b10 : 2'b00;
  assign s_axi_rvalid = (state == RD_DATA);
  assign s_axi_rid    = s_axi_rvalid ? id_q : '0;
  assign s_axi_rdata  = rdata_q;
  assign s_axi_rresp  = (s_axi_rvalid && rresp_err_q) ? 2'b10 : 2'b00;
  assign s_axi_rlast  = s_axi_rvalid && final_beat;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state       <= IDLE;
      id_q        <= '0;
      addr_q      <= '0;
      len_q       <= '0;
      size_q      <= '0;
      burst_q     <= '0;
      beat_q      <= '0;
      illegal_q   <= 1'b0;
      err_q       <= 1'b0;
      prio_rd     <= 1'b0;
      rdata_q     <= '0;
      rresp_err_q <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          beat_q <= '0;
          if (grant_wr) begin
            id_q      <= s_axi_awid;
            addr_q    <= s_axi_awaddr;
            len_q     <= s_axi_awlen;
            size_q    <= s_axi_awsize;
            burst_q   <= s_axi_awburst;
            illegal_q <= is_illegal(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            err_q     <= is_illegal(s_axi_awlen, s_axi_awsize, s_axi_awburst);
            prio_rd   <= 1'b1;
            state     <= WR_REQ;
          end else if (grant_rd) begin
            id_q      <= s_axi_arid;
            addr_q    <= s_axi_araddr;
            len_q     <= s_axi_arlen;
            size_q    <= s_axi_arsize;
            burst_q   <= s_axi_arburst;
            illegal_q <= is_illegal(s_axi_arlen, s_axi_arsize, s_axi_arburst);
            prio_rd   <= 1'b0;
            state     <= RD_REQ;
          end
        end
        WR_REQ: begin
          if (w_accept) begin
            if (s_axi_wlast != final_beat) err_q <= 1'b1;
            // Illegal bursts drain W beats here without touching memory.
            if (!illegal_q)      state <= WR_ACK;
            else if (final_beat) state <= WR_RESP;
            else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_nxt;
            end
          end
        end
        WR_ACK: begin
          if (mem_rsp_valid) begin
            if (mem_rsp_err) err_q <= 1'b1;
            if (final_beat) state <= WR_RESP;
            else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_nxt;
              state  <= WR_REQ;
            end
          end
        end
        WR_RESP: begin
          if (s_axi_bready) state <= IDLE;
        end
        RD_REQ: begin
          if (illegal_q) begin
            rdata_q     <= '0;
            rresp_err_q <= 1'b1;
            state       <= RD_DATA;
          end else if (mem_req_ready) begin
            state <= RD_ACK;
          end
        end
        RD_ACK: begin
          if (mem_rsp_valid) begin
            rdata_q     <= mem_rsp_rdata;
            rresp_err_q <= mem_rsp_err;
            state       <= RD_DATA;
          end
        end
        RD_DATA: begin
          if (s_axi_rready) begin
            if (final_beat) state <= IDLE;
            else begin
              beat_q <= beat_q + 8'd1;
              addr_q <= addr_nxt;
              state  <= RD_REQ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_slave_bridge.sv
// Directed bench for axi_slave_bridge: expected memory requests go into a
// scoreboard queue as stimulus is driven and are matched against observed ones.
module tb_axi_slave_bridge;

  localparam int ADDR_W = 64;
  localparam int DATA_W = 128;
  localparam int ID_W   = 8;

  logic                clk = 1'b0;
  logic                rst = 1'b1;
  logic [ID_W-1:0]     awid = '0;
  logic [ADDR_W-1:0]   awaddr = '0;
  logic [7:0]          awlen = '0;
  logic [2:0]          awsize = '0;
  logic [1:0]          awburst = '0;
  logic                awvalid = 1'b0;
  logic                awready;
  logic [DATA_W-1:0]   wdata = '0;
  logic [DATA_W/8-1:0] wstrb = '0;
  logic                wlast = 1'b0;
  logic                wvalid = 1'b0;
  logic                wready;
  logic [ID_W-1:0]     bid;
  logic [1:0]          bresp;
  logic                bvalid;
  logic                bready = 1'b0;
  logic [ID_W-1:0]     arid = '0;
  logic [ADDR_W-1:0]   araddr = '0;
  logic [7:0]          arlen = '0;
  logic [2:0]          arsize = '0;
  logic [1:0]          arburst = '0;
  logic                arvalid = 1'b0;
  logic                arready;
  logic [ID_W-1:0]     rid;
  logic [DATA_W-1:0]   rdata;
  logic [1:0]          rresp;
  logic                rlast;
  logic                rvalid;
  logic                rready = 1'b0;
  logic                mem_req_valid;
  logic                mem_req_write;
  logic [ADDR_W-1:0]   mem_req_addr;
  logic [DATA_W-1:0]   mem_req_wdata;
  logic [DATA_W/8-1:0] mem_req_wstrb;
  logic                mem_req_ready = 1'b1;
  logic                mem_rsp_valid = 1'b0;
  logic [DATA_W-1:0]   mem_rsp_rdata = '0;
  logic                mem_rsp_err = 1'b0;

  typedef struct {
    logic [ADDR_W-1:0] addr;
    logic              write;
    logic [DATA_W-1:0] data;
  } req_t;

  req_t              exp_q[$];
  req_t              obs_q[$];
  logic [ADDR_W-1:0] rd_addr_q[$];
  int                obs_idx = 0;
  int                rsp_count = 0;
  int                rsp_err_at = -1;
  int                checks = 0;
  int                errors = 0;

  axi_slave_bridge #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .ID_W(ID_W)) dut (
    .clk(clk), .rst(rst),
    .s_axi_awid(awid), .s_axi_awaddr(awaddr), .s_axi_awlen(awlen), .s_axi_awsize(awsize),
    .s_axi_awburst(awburst), .s_axi_awvalid(awvalid), .s_axi_awready(awready),
    .s_axi_wdata(wdata), .s_axi_wstrb(wstrb), .s_axi_wlast(wlast), .s_axi_wvalid(wvalid),
    .s_axi_wready(wready),
    .s_axi_bid(bid), .s_axi_bresp(bresp), .s_axi_bvalid(bvalid), .s_axi_bready(bready),
    .s_axi_arid(arid), .s_axi_araddr(araddr), .s_axi_arlen(arlen), .s_axi_arsize(arsize),
    .s_axi_arburst(arburst), .s_axi_arvalid(arvalid), .s_axi_arready(arready),
    .s_axi_rid(rid), .s_axi_rdata(rdata), .s_axi_rresp(rresp), .s_axi_rlast(rlast),
    .s_axi_rvalid(rvalid), .s_axi_rready(rready),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_wdata(mem_req_wdata), .mem_req_wstrb(mem_req_wstrb), .mem_req_ready(mem_req_ready),
    .mem_rsp_valid(mem_rsp_valid), .mem_rsp_rdata(mem_rsp_rdata), .mem_rsp_err(mem_rsp_err)
  );

  always #5 clk = ~clk;

  // Memory model: logs each accepted request and answers one cycle later with
  // rdata = {~addr, addr}; rsp_err_at selects which response carries an error.
  always begin
    @(negedge clk);
    if (mem_req_valid && mem_req_ready && !rst) begin
      obs_q.push_back('{mem_req_addr, mem_req_write, mem_req_write ? mem_req_wdata : '0});
      @(posedge clk); #1;
      mem_rsp_valid = 1'b1;
      mem_rsp_rdata = {~obs_q[$].addr, obs_q[$].addr};
      mem_rsp_err   = (rsp_count == rsp_err_at);
      rsp_count     = rsp_count + 1;
      @(posedge clk); #1;
      mem_rsp_valid = 1'b0;
      mem_rsp_err   = 1'b0;
    end
  end

  initial begin
    #2000000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic checkOutput(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input bit is_wr, input logic [7:0] id, input logic [63:0] addr,
                               input logic [7:0] len, input logic [2:0] size,
                               input logic [1:0] burst);
    if (is_wr) begin
      awid = id; awaddr = addr; awlen = len; awsize = size; awburst = burst; awvalid = 1'b1;
    end else begin
      arid = id; araddr = addr; arlen = len; arsize = size; arburst = burst; arvalid = 1'b1;
    end
  endtask

  task automatic wait_hs(input bit exp_aw, input bit exp_ar);
    int  n = 0;
    bit  aw_seen, ar_seen;
    do begin
      @(negedge clk);
      n++;
      aw_seen = awready;
      ar_seen = arready;
    end while (!aw_seen && !ar_seen && n < 100);
    checkOutput("awready_grant", aw_seen, exp_aw);
    checkOutput("arready_grant", ar_seen, exp_ar);
    @(posedge clk); #1;
    if (aw_seen) awvalid = 1'b0;
    if (ar_seen) arvalid = 1'b0;
  endtask

  task automatic send_w(input int beats, input int last_at, input logic [63:0] addr0,
                        input bit expect_mem);
    for (int i = 0; i < beats; i++) begin
      int n = 0;
      wdata  = {addr0, 64'(i) ^ 64'h0000_DEAD_BEEF_0000};
      wstrb  = '1;
      wlast  = (i == last_at);
      wvalid = 1'b1;
      if (expect_mem) exp_q.push_back('{addr0 + 64'(16 * i), 1'b1, wdata});
      do begin
        @(negedge clk);
        n++;
      end while (!wready && n < 100);
      checkOutput("wready", wready, 1'b1);
      @(posedge clk); #1;
    end
    wvalid = 1'b0;
    wlast  = 1'b0;
  endtask

  task automatic wait_b(input logic [7:0] id, input logic [1:0] resp);
    int n = 0;
    bready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while (!bvalid && n < 100);
    checkOutput("bvalid", bvalid, 1'b1);
    checkOutput("bid", bid, id);
    checkOutput("bresp", bresp, resp);
    @(posedge clk); #1;
    bready = 1'b0;
  endtask

  task automatic recv_r(input int beats, input logic [7:0] id, input int err_beat,
                        input bit illegal);
    logic [63:0] a;
    rready = 1'b1;
    for (int b = 0; b < beats; b++) begin
      int n = 0;
      a = '0;
      if (!illegal && rd_addr_q.size() > 0) a = rd_addr_q.pop_front();
      do begin
        @(negedge clk);
        n++;
      end while (!rvalid && n < 100);
      checkOutput("rvalid", rvalid, 1'b1);
      checkOutput("rid", rid, id);
      checkOutput("rdata", rdata, illegal ? 128'h0 : {~a, a});
      checkOutput("rresp", rresp, (illegal || b == err_beat) ? 2'b10 : 2'b00);
      checkOutput("rlast", rlast, b == beats - 1);
      @(posedge clk); #1;
    end
    rready = 1'b0;
  endtask

  task automatic push_rd(input logic [63:0] addr);
    exp_q.push_back('{addr, 1'b0, '0});
    rd_addr_q.push_back(addr);
  endtask

  task automatic compare_mem();
    req_t e, o;
    int   n = 0;
    while (obs_q.size() < obs_idx + exp_q.size() && n < 100) begin
      @(posedge clk);
      n++;
    end
    while (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      if (obs_idx < obs_q.size()) begin
        o = obs_q[obs_idx];
        obs_idx++;
        checkOutput("mem_addr", o.addr, e.addr);
        checkOutput("mem_write", o.write, e.write);
        if (e.write) checkOutput("mem_wdata", o.data, e.data);
      end else begin
        checkOutput("mem_missing", 1'b0, 1'b1);
      end
    end
    checkOutput("mem_extra", 128'(obs_q.size() - obs_idx), 128'h0);
  endtask

  initial begin
    logic [63:0] a;
    int          n;

    // Reset state
    repeat (3) @(posedge clk);
    @(negedge clk);
    checkOutput("rst_awready", awready, 1'b0);
    checkOutput("rst_wready", wready, 1'b0);
    checkOutput("rst_bvalid", bvalid, 1'b0);
    checkOutput("rst_rvalid", rvalid, 1'b0);
    checkOutput("rst_mem_valid", mem_req_valid, 1'b0);
    checkOutput("rst_rdata", rdata, 128'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    @(posedge clk); #1;

    // Simultaneous AW/AR twice: write first, then read, then the queued write
    applyStimulus(1'b1, 8'd1, 64'h1000, 8'd3, 3'd4, 2'b01);
    applyStimulus(1'b0, 8'd2, 64'h1038, 8'd3, 3'd4, 2'b10);
    wait_hs(1'b1, 1'b0);
    send_w(4, 3, 64'h1000, 1'b1);
    applyStimulus(1'b1, 8'd3, 64'h4000, 8'd0, 3'd4, 2'b01);
    wait_b(8'd1, 2'b00);
    compare_mem();
    push_rd(64'h1030); push_rd(64'h1000); push_rd(64'h1010); push_rd(64'h1020);
    wait_hs(1'b0, 1'b1);
    recv_r(4, 8'd2, -1, 1'b0);
    compare_mem();
    wait_hs(1'b1, 1'b0);
    send_w(1, 0, 64'h4000, 1'b1);
    wait_b(8'd3, 2'b00);
    compare_mem();

    // Early wlast still yields len+1 writes and SLVERR
    applyStimulus(1'b1, 8'd6, 64'h5000, 8'd1, 3'd4, 2'b01);
    wait_hs(1'b1, 1'b0);
    send_w(2, 0, 64'h5000, 1'b1);
    wait_b(8'd6, 2'b10);
    compare_mem();

    // Memory error on the second read beat only
    rsp_err_at = rsp_count + 1;
    push_rd(64'h6000); push_rd(64'h6010);
    applyStimulus(1'b0, 8'd7, 64'h6000, 8'd1, 3'd4, 2'b01);
    wait_hs(1'b0, 1'b1);
    recv_r(2, 8'd7, 1, 1'b0);
    compare_mem();
    rsp_err_at = -1;

    // Illegal bursts never reach memory
    applyStimulus(1'b1, 8'd8, 64'h7000, 8'd1, 3'd4, 2'b11);
    wait_hs(1'b1, 1'b0);
    send_w(2, 1, 64'h7000, 1'b0);
    wait_b(8'd8, 2'b10);
    compare_mem();
    applyStimulus(1'b0, 8'd9, 64'h8000, 8'd2, 3'd5, 2'b01);
    wait_hs(1'b0, 1'b1);
    recv_r(3, 8'd9, -1, 1'b1);
    compare_mem();

    // rready stall keeps R stable, then reset lands mid-burst
    a = 64'h2000;
    exp_q.push_back('{a, 1'b0, '0});
    applyStimulus(1'b0, 8'd5, a, 8'd1, 3'd4, 2'b01);
    wait_hs(1'b0, 1'b1);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!rvalid && n < 100);
    for (int c = 0; c < 5; c++) begin
      checkOutput("stall_rvalid", rvalid, 1'b1);
      checkOutput("stall_rdata", rdata, {~a, a});
      @(negedge clk);
    end
    @(posedge clk); #1;
    rst = 1'b1;
    #1;
    checkOutput("arst_rvalid", rvalid, 1'b0);
    checkOutput("arst_rdata", rdata, 128'h0);
    checkOutput("arst_rid", rid, 8'h0);
    checkOutput("arst_rlast", rlast, 1'b0);
    checkOutput("arst_mem_valid", mem_req_valid, 1'b0);
    checkOutput("arst_mem_addr", mem_req_addr, 64'h0);
    checkOutput("arst_arready", arready, 1'b0);
    compare_mem();
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;
    @(posedge clk); #1;
    applyStimulus(1'b1, 8'd10, 64'h3000, 8'd0, 3'd4, 2'b01);
    wait_hs(1'b1, 1'b0);
    send_w(1, 0, 64'h3000, 1'b1);
    wait_b(8'd10, 2'b00);
    compare_mem();

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/axi_slave_bridge.md
AXI_SLAVE_BRIDGE -- requirements
Module: axi_slave_bridge

Interface
REQ-001 SHALL have parameter ADDR_W, default 64, AXI and memory address width.
REQ-002 SHALL have parameter DATA_W, default 128, data width; legal values 32, 64, 128, 256, 512.
REQ-003 SHALL have parameter ID_W, default 8, AXI ID width.
REQ-004 SHALL have port clk, input, 1, sole clock; all logic on the rising edge.
REQ-005 SHALL have port rst, input, 1, reset: asynchronous, active-high.
REQ-006 SHALL have AW ports, inputs: s_axi_awid ID_W, s_axi_awaddr ADDR_W, s_axi_awlen 8, s_axi_awsize 3, s_axi_awburst 2, s_axi_awvalid 1; output s_axi_awready 1.
REQ-007 SHALL have W ports, inputs: s_axi_wdata DATA_W, s_axi_wstrb DATA_W/8, s_axi_wlast 1, s_axi_wvalid 1; output s_axi_wready 1.
REQ-008 SHALL have B ports, outputs: s_axi_bid ID_W, s_axi_bresp 2, s_axi_bvalid 1; input s_axi_bready 1.
REQ-009 SHALL have AR ports, inputs: s_axi_arid ID_W, s_axi_araddr ADDR_W, s_axi_arlen 8, s_axi_arsize 3, s_axi_arburst 2, s_axi_arvalid 1; output s_axi_arready 1.
REQ-010 SHALL have R ports, outputs: s_axi_rid ID_W, s_axi_rdata DATA_W, s_axi_rresp 2, s_axi_rlast 1, s_axi_rvalid 1; input s_axi_rready 1.
REQ-011 SHALL have memory request ports: outputs mem_req_valid 1, mem_req_write 1, mem_req_addr ADDR_W, mem_req_wdata DATA_W, mem_req_wstrb DATA_W/8; input mem_req_ready 1.
REQ-012 SHALL have memory response ports, inputs: mem_rsp_valid 1, mem_rsp_rdata DATA_W, mem_rsp_err 1; no backpressure; one request outstanding at most.

Function
REQ-013 SHALL implement FSM states IDLE, WR_REQ, WR_ACK, WR_RESP, RD_REQ, RD_ACK, RD_DATA.
REQ-014 SHALL in IDLE assert awready or arready (never both) for one cycle when the corresponding valid is high, latching id/addr/len/size/burst; next state WR_REQ or RD_REQ.
REQ-015 SHALL arbitrate simultaneous awvalid and arvalid round-robin: the channel not served last wins; after reset write wins.
REQ-016 SHALL in WR_REQ drive mem_req_valid=wvalid, mem_req_write=1, current beat address, wdata, wstrb; wready=mem_req_ready; on wvalid&mem_req_ready go WR_ACK.
REQ-017 SHALL in WR_ACK wait mem_rsp_valid; OR mem_rsp_err into a sticky error flag; then WR_REQ if beats remain, else WR_RESP.
REQ-018 SHALL in WR_RESP hold bvalid=1, bid=latched id, bresp=2'b10 (SLVERR) if sticky error else 2'b00, until bready; then IDLE.
REQ-019 SHALL set sticky error when wlast disagrees with the final-beat position (early or missing); beat count always follows awlen+1.
REQ-020 SHALL in RD_REQ drive mem_req_valid=1, mem_req_write=0, current address; on mem_req_ready go RD_ACK.
REQ-021 SHALL in RD_ACK capture mem_rsp_rdata into the R register and rresp=SLVERR if mem_rsp_err, on mem_rsp_valid; go RD_DATA.
REQ-022 SHALL in RD_DATA hold rvalid=1, rid, rdata, rresp, rlast=(final beat) stable until rready; then RD_REQ or IDLE.
REQ-023 SHALL compute next beat address: FIXED(00) unchanged; INCR(01) aligned(addr)+2^size; WRAP(10) wraps within (len+1)*2^size-byte boundary; ADDR_W-bit arithmetic, overflow discarded.
REQ-024 SHALL flag a burst illegal if burst=11, size>log2(DATA_W/8), or WRAP with len not in {1,3,7,15}.
REQ-025 SHALL for illegal writes consume all W beats (wready=1, no mem request) and return SLVERR; for illegal reads return len+1 beats of rdata=0, rresp=SLVERR, without mem requests.
REQ-026 SHALL use an 8-bit beat counter; len=255 yields 256 beats.
REQ-027 SHALL ignore mem_rsp_valid outside WR_ACK/RD_ACK.

Reset
REQ-028 SHALL on rst force IDLE, all ready/valid outputs 0, bresp/rresp/rdata/bid/rid/mem_req_* 0, sticky error 0, arbiter priority to write; an in-flight burst is abandoned.

Verification
REQ-029 SHALL cover: INCR write awaddr=0x1000 len=3 size=4, mem always ready/ack -> mem addresses 0x1000/0x1010/0x1020/0x1030, bresp=00.
REQ-030 SHALL cover: WRAP read araddr=0x1038 len=3 size=4 -> addresses 0x1030,0x1000,0x1010,0x1020; rlast on 4th beat only.
REQ-031 SHALL cover: awvalid and arvalid same cycle twice in succession -> write served first, read second.
REQ-032 SHALL cover: write len=1 with wlast on beat 0 -> two mem writes, bresp=10; read with mem_rsp_err on beat 1 of 2 -> rresp 00 then 10.
REQ-033 SHALL cover: rready low 5 cycles in RD_DATA -> rdata/rvalid stable; rst asserted mid-burst -> all outputs 0 same cycle, next AW accepted normally.
